// File: rtl/exc_pkg.sv
// Shared constants for the exception/interrupt controller.
package exc_pkg;

  // Special-purpose register select encodings (movg2s / movs2g).
  typedef enum logic [1:0] {
    SPR_SR  = 2'd0,
    SPR_ESR = 2'd1,
    SPR_ECA = 2'd2,
    SPR_EPC = 2'd3
  } spr_sel_e;

  // Bit positions inside the cause vector.
  localparam int unsigned CA_ILL  = 0;
  localparam int unsigned CA_SYS  = 1;
  localparam int unsigned CA_OVF  = 2;
  localparam int unsigned CA_EXT0 = 3;

  // Internal causes whose handler must re-execute the faulting instruction.
  localparam logic [2:0] REPEAT_MASK = 3'b101;

  // Internal causes that ignore SR.
  localparam logic [2:0] UNMASKABLE = 3'b011;

endpackage

// File: rtl/int_sync.sv
// Two-flop synchronizer for asynchronous level-sensitive lines.
module int_sync #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Double-register the asynchronous inputs into the clk domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller: cause sampling, SPR file, jisr/eret pulses.
module exc_ctrl
  import exc_pkg::*;
#(
  parameter int unsigned NUM_EXT = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               exe,
  input  logic [31:0]        pc,
  input  logic [31:0]        next_pc,
  input  logic               ill,
  input  logic               sys,
  input  logic               ovf,
  input  logic               is_eret,
  input  logic [NUM_EXT-1:0] ext_int,
  input  logic               spr_we,
  input  logic [1:0]         spr_sel,
  input  logic [31:0]        spr_wdata,
  output logic [31:0]        spr_rdata,
  output logic               jisr,
  output logic               eret,
  output logic [31:0]        epc,
  output logic [NUM_EXT+2:0] sr
);

  localparam int unsigned ECA_W = 3 + NUM_EXT;

  logic [NUM_EXT-1:0] ext_s;
  logic [ECA_W-1:0]   ca, mca, gate;
  logic [ECA_W-1:0]   sr_q, esr_q, eca_q;
  logic [ECA_W-1:0]   sr_d, esr_d, eca_d;
  logic [31:0]        epc_q, epc_d;
  logic               jisr_d, eret_d;
  logic               take_exc, take_eret, take_wr;
  spr_sel_e           sel;

  int_sync #(.W(NUM_EXT)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (ext_int),
    .q   (ext_s)
  );

  assign sel = spr_sel_e'(spr_sel);

  // Cause vector assembly and SR gating of maskable causes.
  always_comb begin
    ca                       = '0;
    ca[CA_ILL]               = ill;
    ca[CA_SYS]               = sys;
    ca[CA_OVF]               = ovf;
    ca[ECA_W-1:CA_EXT0]      = ext_s;
    gate                     = sr_q | {{(ECA_W-3){1'b0}}, UNMASKABLE};
    mca                      = ca & gate;
    take_exc                 = exe && (|mca);
    take_eret                = exe && is_eret && !(|mca);
    take_wr                  = exe && spr_we && !(|mca);
  end

  // Next-state for the SPR file and the pulse outputs.
  // The SPR write is applied before eret so SR picks up a freshly written ESR.
  always_comb begin
    sr_d   = sr_q;
    esr_d  = esr_q;
    eca_d  = eca_q;
    epc_d  = epc_q;
    jisr_d = 1'b0;
    eret_d = 1'b0;
    if (take_exc) begin
      eca_d  = mca;
      esr_d  = sr_q;
      sr_d   = '0;
      epc_d  = (|(mca[2:0] & REPEAT_MASK)) ? pc : next_pc;
      jisr_d = 1'b1;
    end else begin
      if (take_wr) begin
        case (sel)
          SPR_SR:  sr_d  = spr_wdata[ECA_W-1:0];
          SPR_ESR: esr_d = spr_wdata[ECA_W-1:0];
          SPR_ECA: eca_d = spr_wdata[ECA_W-1:0];
          SPR_EPC: epc_d = spr_wdata;
        endcase
      end
      if (take_eret) begin
        sr_d   = esr_d;
        eret_d = 1'b1;
      end
    end
  end

  // SPR and pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q  <= '0;
      esr_q <= '0;
      eca_q <= '0;
      epc_q <= '0;
      jisr  <= 1'b0;
      eret  <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      esr_q <= esr_d;
      eca_q <= eca_d;
      epc_q <= epc_d;
      jisr  <= jisr_d;
      eret  <= eret_d;
    end
  end

  // Combinational SPR read, zero-extended to 32 bits.
  always_comb begin
    spr_rdata = '0;
    case (sel)
      SPR_SR:  spr_rdata = 32'(sr_q);
      SPR_ESR: spr_rdata = 32'(esr_q);
      SPR_ECA: spr_rdata = 32'(eca_q);
      SPR_EPC: spr_rdata = epc_q;
    endcase
  end

  assign epc = epc_q;
  assign sr  = sr_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed self-checking bench for exc_ctrl.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        exe, ill, sys, ovf, is_eret, spr_we;
  logic [31:0] pc, next_pc, spr_wdata;
  logic [2:0]  ext_int;
  logic [1:0]  spr_sel;
  logic [31:0] spr_rdata, epc;
  logic        jisr, eret;
  logic [5:0]  sr;

  int n_chk  = 0;
  int n_fail = 0;

  exc_ctrl #(.NUM_EXT(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .exe       (exe),
    .pc        (pc),
    .next_pc   (next_pc),
    .ill       (ill),
    .sys       (sys),
    .ovf       (ovf),
    .is_eret   (is_eret),
    .ext_int   (ext_int),
    .spr_we    (spr_we),
    .spr_sel   (spr_sel),
    .spr_wdata (spr_wdata),
    .spr_rdata (spr_rdata),
    .jisr      (jisr),
    .eret      (eret),
    .epc       (epc),
    .sr        (sr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        exe;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        ill, sys, ovf, ise, we;
    logic [1:0]  sel;
    logic [31:0] wd;
    logic        ej, ee;
    logic [31:0] eepc;
    logic [5:0]  esr;
    logic [31:0] erd;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic e, logic [31:0] p, logic [31:0] np,
                              logic i, logic s, logic o, logic r, logic w,
                              logic [1:0] sl, logic [31:0] d,
                              logic ej, logic ee, logic [31:0] xepc,
                              logic [5:0] xsr, logic [31:0] xrd);
    vec_t v;
    v.exe = e; v.pc = p; v.npc = np; v.ill = i; v.sys = s; v.ovf = o;
    v.ise = r; v.we = w; v.sel = sl; v.wd = d;
    v.ej = ej; v.ee = ee; v.eepc = xepc; v.esr = xsr; v.erd = xrd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    exe = 0; pc = '0; next_pc = '0; ill = 0; sys = 0; ovf = 0;
    is_eret = 0; spr_we = 0; spr_sel = 2'd0; spr_wdata = '0;
  endtask

  task automatic drive(input vec_t v);
    exe = v.exe; pc = v.pc; next_pc = v.npc; ill = v.ill; sys = v.sys;
    ovf = v.ovf; is_eret = v.ise; spr_we = v.we; spr_sel = v.sel;
    spr_wdata = v.wd;
  endtask

  initial begin
    idle();
    ext_int = '0;
    rst = 1'b0;

    //      exe pc     npc    ill sys ovf ere we sel wdata          jisr eret epc           sr     rdata
    vt.push_back(mk(0, 32'h0,  32'h0,  0, 0, 0, 0, 0, 2'd0, 32'h0,        0, 0, 32'h0,        6'h00, 32'h0));
    vt.push_back(mk(1, 32'h40, 32'h44, 1, 0, 0, 0, 0, 2'd2, 32'h0,        1, 0, 32'h40,       6'h00, 32'h01));
    vt.push_back(mk(0, 32'h0,  32'h0,  0, 0, 0, 0, 0, 2'd3, 32'h0,        0, 0, 32'h40,       6'h00, 32'h40));
    vt.push_back(mk(1, 32'h50, 32'h54, 0, 0, 0, 0, 1, 2'd0, 32'h3C,       0, 0, 32'h40,       6'h3C, 32'h3C));
    vt.push_back(mk(1, 32'h10, 32'h14, 0, 1, 1, 0, 0, 2'd1, 32'h0,        1, 0, 32'h10,       6'h00, 32'h3C));
    vt.push_back(mk(0, 32'h0,  32'h0,  0, 0, 0, 0, 0, 2'd2, 32'h0,        0, 0, 32'h10,       6'h00, 32'h06));
    vt.push_back(mk(1, 32'h20, 32'h24, 0, 0, 1, 0, 0, 2'd2, 32'h0,        0, 0, 32'h10,       6'h00, 32'h06));
    vt.push_back(mk(1, 32'h24, 32'h28, 0, 0, 0, 1, 0, 2'd0, 32'h0,        0, 1, 32'h10,       6'h3C, 32'h3C));
    vt.push_back(mk(0, 32'h0,  32'h0,  0, 0, 0, 0, 0, 2'd0, 32'h0,        0, 0, 32'h10,       6'h3C, 32'h3C));
    vt.push_back(mk(1, 32'h80, 32'h84, 1, 0, 0, 1, 0, 2'd1, 32'h0,        1, 0, 32'h80,       6'h00, 32'h3C));
    vt.push_back(mk(0, 32'h0,  32'h0,  0, 0, 0, 0, 0, 2'd2, 32'h0,        0, 0, 32'h80,       6'h00, 32'h01));
    vt.push_back(mk(1, 32'h0,  32'h0,  0, 0, 0, 1, 1, 2'd1, 32'hFFFFFF15, 0, 1, 32'h80,       6'h15, 32'h15));
    vt.push_back(mk(0, 32'h0,  32'h0,  1, 0, 0, 0, 1, 2'd3, 32'h1234,     0, 0, 32'h80,       6'h15, 32'h80));
    vt.push_back(mk(1, 32'h90, 32'h94, 0, 1, 0, 0, 1, 2'd3, 32'h1234,     1, 0, 32'h94,       6'h00, 32'h94));
    vt.push_back(mk(0, 32'h0,  32'h0,  0, 0, 0, 0, 0, 2'd1, 32'h0,        0, 0, 32'h94,       6'h00, 32'h15));
    vt.push_back(mk(1, 32'h0,  32'h0,  0, 0, 0, 0, 1, 2'd2, 32'h0,        0, 0, 32'h94,       6'h00, 32'h0));
    vt.push_back(mk(1, 32'h0,  32'h0,  0, 0, 0, 0, 1, 2'd3, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 6'h00, 32'hDEADBEEF));

    // Reset state while held in reset.
    repeat (2) @(negedge clk);
    chk("rst jisr", 32'(jisr), 32'h0);
    chk("rst eret", 32'(eret), 32'h0);
    chk("rst epc", epc, 32'h0);
    chk("rst sr", 32'(sr), 32'h0);
    rst = 1'b1;

    // Table-driven vectors: inputs applied at a falling edge, results checked one cycle later.
    foreach (vt[i]) begin
      drive(vt[i]);
      @(negedge clk);
      chk($sformatf("v%0d jisr", i), 32'(jisr), 32'(vt[i].ej));
      chk($sformatf("v%0d eret", i), 32'(eret), 32'(vt[i].ee));
      chk($sformatf("v%0d epc", i), epc, vt[i].eepc);
      chk($sformatf("v%0d sr", i), 32'(sr), 32'(vt[i].esr));
      chk($sformatf("v%0d rdata", i), spr_rdata, vt[i].erd);
    end

    // External line held while masked, then unmasked, then retrigger after eret.
    idle();
    ext_int = 3'b010;
    exe = 1; pc = 32'h100; next_pc = 32'h104;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("ext masked jisr %0d", k), 32'(jisr), 32'h0);
    end
    spr_we = 1; spr_sel = 2'd0; spr_wdata = 32'h10;
    @(negedge clk);
    chk("ext sr write", 32'(sr), 32'h10);
    chk("ext sr write jisr", 32'(jisr), 32'h0);
    spr_we = 0; spr_sel = 2'd2;
    @(negedge clk);
    chk("ext jisr", 32'(jisr), 32'h1);
    chk("ext eca", spr_rdata, 32'h10);
    chk("ext epc", epc, 32'h104);
    chk("ext sr cleared", 32'(sr), 32'h0);
    exe = 0; spr_sel = 2'd1;
    @(negedge clk);
    chk("ext jisr drop", 32'(jisr), 32'h0);
    chk("ext esr", spr_rdata, 32'h10);
    exe = 1; is_eret = 1; spr_sel = 2'd0;
    @(negedge clk);
    chk("ext eret", 32'(eret), 32'h1);
    chk("ext eret jisr", 32'(jisr), 32'h0);
    chk("ext eret sr", 32'(sr), 32'h10);
    exe = 0; is_eret = 0;
    @(negedge clk);
    chk("ext eret drop", 32'(eret), 32'h0);
    exe = 1;
    @(negedge clk);
    chk("ext retrigger", 32'(jisr), 32'h1);
    exe = 0; ext_int = '0;
    repeat (3) @(negedge clk);

    // Synchronizer latency: line rises, exception visible after the third edge.
    exe = 1; spr_we = 1; spr_sel = 2'd0; spr_wdata = 32'h38;
    @(negedge clk);
    chk("lat sr", 32'(sr), 32'h38);
    spr_we = 0; spr_sel = 2'd2; pc = 32'h200; next_pc = 32'h204;
    ext_int = 3'b100;
    @(negedge clk);
    chk("lat edge1", 32'(jisr), 32'h0);
    @(negedge clk);
    chk("lat edge2", 32'(jisr), 32'h0);
    @(negedge clk);
    chk("lat edge3", 32'(jisr), 32'h1);
    chk("lat eca", spr_rdata, 32'h20);
    chk("lat epc", epc, 32'h204);
    idle();
    ext_int = '0;
    repeat (3) @(negedge clk);

    // Asynchronous reset during a jisr pulse.
    exe = 1; ill = 1; pc = 32'h300; next_pc = 32'h304; spr_sel = 2'd2;
    @(negedge clk);
    chk("rstp jisr before", 32'(jisr), 32'h1);
    idle();
    spr_sel = 2'd2;
    rst = 1'b0;
    #1;
    chk("rstp jisr", 32'(jisr), 32'h0);
    chk("rstp sr", 32'(sr), 32'h0);
    chk("rstp epc", epc, 32'h0);
    chk("rstp eca", spr_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
